// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
// The LFSR step and pattern shaping live here so the LFSR and the controller agree on them.
package mole_pkg;

    localparam int unsigned NUM_HOLES = 18;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SPAWN  = 3'd1,
        S_ACTIVE = 3'd2,
        S_SCORE  = 3'd3,
        S_GAP    = 3'd4,
        S_DONE   = 3'd5
    } mole_state_t;

    // Right-shifting Galois form of x^18 + x^11 + 1
    localparam logic [NUM_HOLES-1:0] LFSR_TAPS        = 18'h20400;
    localparam logic [NUM_HOLES-1:0] PATTERN_FALLBACK = 18'h00001;

    function automatic logic [NUM_HOLES-1:0] lfsr_step(input logic [NUM_HOLES-1:0] v);
        return {1'b0, v[NUM_HOLES-1:1]} ^ (v[0] ? LFSR_TAPS : '0);
    endfunction

    // AND with a half-rotation thins the pattern to roughly a quarter of the holes
    function automatic logic [NUM_HOLES-1:0] make_pattern(input logic [NUM_HOLES-1:0] v);
        logic [NUM_HOLES-1:0] p;
        p = v & {v[8:0], v[17:9]};
        return (p == '0) ? PATTERN_FALLBACK : p;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 18-bit Galois LFSR with synchronous active-low load to seed and an advance enable.
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [NUM_HOLES-1:0] SEED = 18'h2A5F3
) (
    input  logic                 clk,
    input  logic                 load_n,
    input  logic                 advance,
    output logic [NUM_HOLES-1:0] value
);

    always_ff @(posedge clk) begin
        if (!load_n) begin
            value <= SEED;
        end else if (advance) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/mole_round_ctrl.sv
// Round controller: spawns a mole pattern, captures hits on lit holes during a timed
// window, and presents the hit mask for exactly one SCORE cycle per round.
module mole_round_ctrl
    import mole_pkg::*;
#(
    parameter int unsigned          ROUND_CYCLES = 50_000_000,
    parameter int unsigned          GAP_CYCLES   = 12_500_000,
    parameter int unsigned          NUM_ROUNDS   = 30,
    parameter logic [NUM_HOLES-1:0] LFSR_SEED    = 18'h2A5F3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [17:0] sw,
    output logic [17:0] led_moles,
    output logic [17:0] hit_reg,
    output logic        round_done,
    output logic [7:0]  round_idx,
    output logic        game_over
);

    localparam int unsigned TMAX = (ROUND_CYCLES > GAP_CYCLES) ? ROUND_CYCLES : GAP_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX);
    localparam logic [TW-1:0] ROUND_LAST = TW'(ROUND_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

    mole_state_t          state;
    logic [TW-1:0]        timer;
    logic [NUM_HOLES-1:0] pattern;
    logic [NUM_HOLES-1:0] hit_acc;
    logic [NUM_HOLES-1:0] hit_next;
    logic [NUM_HOLES-1:0] sw_prev;
    logic [NUM_HOLES-1:0] lfsr_value;
    logic [7:0]           round_inc;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .load_n  (reset),
        .advance (state == S_SPAWN),
        .value   (lfsr_value)
    );

    // Not reset: the first post-reset cycle must compare against the live switches
    always_ff @(posedge clk) begin
        sw_prev <= sw;
    end

    always_comb begin
        hit_next  = hit_acc | ((sw ^ sw_prev) & pattern);
        round_inc = round_idx + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            pattern    <= '0;
            hit_acc    <= '0;
            led_moles  <= '0;
            hit_reg    <= '0;
            round_done <= 1'b0;
            round_idx  <= '0;
            game_over  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) state <= S_SPAWN;
                end
                S_SPAWN: begin
                    // Pattern is taken from the value the LFSR advances to on this edge
                    pattern   <= make_pattern(lfsr_step(lfsr_value));
                    led_moles <= make_pattern(lfsr_step(lfsr_value));
                    hit_acc   <= '0;
                    timer     <= '0;
                    state     <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    hit_acc <= hit_next;
                    timer   <= timer + TW'(1);
                    if (timer == ROUND_LAST || hit_next == pattern) begin
                        hit_reg    <= hit_next;
                        round_done <= 1'b1;
                        state      <= S_SCORE;
                    end
                end
                S_SCORE: begin
                    hit_reg    <= '0;
                    round_done <= 1'b0;
                    led_moles  <= '0;
                    timer      <= '0;
                    round_idx  <= round_inc;
                    if (round_inc == 8'(NUM_ROUNDS)) begin
                        game_over <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (timer == GAP_LAST) begin
                        state <= S_SPAWN;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_DONE: begin
                    if (start) begin
                        round_idx <= '0;
                        game_over <= 1'b0;
                        state     <= S_SPAWN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mole_round_ctrl.md
# mole_round_ctrl

Round controller for the whack-a-mole game, directly upstream of the score counter. Generates a pseudo-random 18-bit mole pattern each round and drives it to the LEDs. Captures player switch toggles on lit holes during a timed window. At round end, presents the captured hit mask for exactly one cycle so the scorer adds each round exactly once.

## Interface
- `ROUND_CYCLES`, default 50_000_000: ACTIVE window length in clk cycles, ≥ 2.
- `GAP_CYCLES`, default 12_500_000: LEDs-off pause between rounds, ≥ 1.
- `NUM_ROUNDS`, default 30: rounds per game, 1..255.
- `LFSR_SEED`, default 18'h2A5F3: LFSR reset value, nonzero.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-low.
- `start` in 1: level-sampled start request, already synchronized.
- `sw` in 18: synchronized player switches, one per hole.
- `led_moles` out 18: current mole pattern.
- `hit_reg` out 18: captured hits; nonzero only in the SCORE cycle.
- `round_done` out 1: high exactly in the SCORE cycle.
- `round_idx` out 8: rounds completed in the current game.
- `game_over` out 1: high in DONE.

## Operation
- States: IDLE, SPAWN, ACTIVE, SCORE, GAP, DONE.
- IDLE: `start`=1 → SPAWN. DONE: `start`=1 → SPAWN and clear `round_idx` to 0. `start` is ignored in all other states.
- SPAWN, 1 cycle: advance the LFSR once.
  - Load pattern = lfsr & {lfsr[8:0], lfsr[17:9]}. If the result is 0, load 18'h00001.
  - Clear `hit_acc` and the timer. Next state is ACTIVE.
- ACTIVE:
  - `led_moles` = pattern.
  - change = sw ^ sw_prev.
  - hit_acc |= change & pattern. Toggles on unlit holes are discarded.
  - The timer counts 0..ROUND_CYCLES-1.
- ACTIVE exits to SCORE when the timer reaches ROUND_CYCLES-1, or when (hit_acc | new hits) == pattern (early clear). Both conditions in the same cycle → SCORE, counted as one round.
- SCORE, 1 cycle:
  - `hit_reg` = hit_acc, `led_moles` = pattern, `round_done` = 1.
  - Increment `round_idx`.
  - Next state is DONE if the incremented value equals NUM_ROUNDS, otherwise GAP.
- GAP: `led_moles` = 0 for GAP_CYCLES cycles, then SPAWN.
- DONE: `game_over` = 1 and `led_moles` = 0. `round_idx` holds at NUM_ROUNDS.
- LFSR: 18-bit Galois, polynomial x^18+x^11+1, maximal length. It advances only in SPAWN, so the pattern sequence is deterministic from `LFSR_SEED`.
- `sw_prev` loads `sw` every cycle, including during reset, so the first cycle after reset never sees a spurious toggle.

## Timing
- Reset (`reset`=0 at a clk edge) → state IDLE, LFSR = `LFSR_SEED`, `hit_acc` = 0, timer = 0.
- All outputs are 0 after reset: `led_moles`, `hit_reg`, `round_done`, `round_idx`, `game_over`.
- Reset mid-operation (any state) takes effect at that edge. A pending SCORE is lost.
- Cycle timeline, with `start` sampled at edge k:
  - SPAWN during cycle k+1.
  - `led_moles` valid from cycle k+2.
  - Full-length ACTIVE occupies cycles k+2..k+1+ROUND_CYCLES.
  - SCORE at k+2+ROUND_CYCLES.
- A toggle sampled in the last ACTIVE cycle is included in `hit_reg`.
- Early clear: the final hit sampled at edge t → SCORE during cycle t+1.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package `mole_pkg`:
  - `NUM_HOLES` = 18.
  - State enum `mole_state_t`.
  - `LFSR_TAPS` constant.
  - Pattern-to-nonzero fallback constant 18'h00001.
- Sub-module `mole_lfsr`: 18-bit Galois LFSR with synchronous active-low load to seed and an `advance` enable.
- Everything else (FSM, timers, hit capture) lives in `mole_round_ctrl`.

## Test plan
Test parameters: ROUND_CYCLES=8, GAP_CYCLES=2, NUM_ROUNDS=3.

1. Hold reset 2 cycles → all outputs 0. `start` high for 1 cycle → `led_moles` equals the model pattern for seed 18'h2A5F3 at cycle k+2, and is nonzero.
2. No switch activity → SCORE at k+10 with `hit_reg`=0 and `round_done`=1 for exactly one cycle. `round_idx`=1.
3. At ACTIVE cycle 3, toggle every switch whose LED is lit → SCORE on the next cycle, `hit_reg`==`led_moles`, timer abandoned.
4. Toggle one unlit hole and one lit hole (up, then back down later) → `hit_reg` has exactly the lit bit set; the double toggle counts once.
5. Play 3 rounds → `game_over`=1 and `round_idx`=3 after the third SCORE, `led_moles`=0. `start` → `round_idx`=0 and the next pattern continues the LFSR sequence.
6. Assert reset during ACTIVE with hits captured → next cycle all outputs 0. No `round_done` pulse is ever emitted for that round.
